// File: rtl/udp_tx_arbiter.sv
// Three-port round-robin packet arbiter feeding a single registered byte stream.
// Optional length check enabled by defining UDP_TX_ARB_LEN_CHECK_EN.
module udp_tx_arbiter #(
  parameter int GAP_CYCLES = 2,
  parameter int LEN_W      = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [7:0]       i_s0_data,
  input  logic [LEN_W-1:0] i_s0_user,
  input  logic             i_s0_valid,
  input  logic             i_s0_last,
  output logic             o_s0_ready,
  input  logic [7:0]       i_s1_data,
  input  logic [LEN_W-1:0] i_s1_user,
  input  logic             i_s1_valid,
  input  logic             i_s1_last,
  output logic             o_s1_ready,
  input  logic [7:0]       i_s2_data,
  input  logic [LEN_W-1:0] i_s2_user,
  input  logic             i_s2_valid,
  input  logic             i_s2_last,
  output logic             o_s2_ready,
  output logic [LEN_W-1:0] o_send_len,
  output logic [7:0]       o_send_data,
  output logic             o_send_valid,
  output logic             o_send_last,
  input  logic             i_send_ready,
  output logic [1:0]       o_grant,
  output logic             o_busy,
  output logic             o_err_len,
  output logic [7:0]       o_err_cnt
);

  typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t           state;
  logic [1:0]       rr_ptr;
  logic [LEN_W-1:0] beat_cnt;
  logic [GW-1:0]    gap_cnt;
  logic             in_done;

  logic [2:0]       req;
  logic [1:0]       pick, o0, o1, o2;
  logic             found;
  logic [LEN_W-1:0] pick_user;
  logic             cur_valid, cur_last;
  logic [7:0]       cur_data;
  logic             can_take, take, out_hs;

  assign req = {i_s2_valid, i_s1_valid, i_s0_valid};

  // Search order starts one past the last granted port.
  always_comb begin
    case (rr_ptr)
      2'd0:    begin o0 = 2'd1; o1 = 2'd2; o2 = 2'd0; end
      2'd1:    begin o0 = 2'd2; o1 = 2'd0; o2 = 2'd1; end
      default: begin o0 = 2'd0; o1 = 2'd1; o2 = 2'd2; end
    endcase
    found = 1'b1;
    if (req[o0])      pick = o0;
    else if (req[o1]) pick = o1;
    else if (req[o2]) pick = o2;
    else begin
      pick  = 2'd0;
      found = 1'b0;
    end
  end

  always_comb begin
    case (pick)
      2'd0:    pick_user = i_s0_user;
      2'd1:    pick_user = i_s1_user;
      default: pick_user = i_s2_user;
    endcase
  end

  always_comb begin
    cur_valid = 1'b0;
    cur_data  = 8'd0;
    cur_last  = 1'b0;
    case (o_grant)
      2'd0:    begin cur_valid = i_s0_valid; cur_data = i_s0_data; cur_last = i_s0_last; end
      2'd1:    begin cur_valid = i_s1_valid; cur_data = i_s1_data; cur_last = i_s1_last; end
      2'd2:    begin cur_valid = i_s2_valid; cur_data = i_s2_data; cur_last = i_s2_last; end
      default: begin cur_valid = 1'b0; cur_data = 8'd0; cur_last = 1'b0; end
    endcase
  end

  // The output register can take a beat whenever it is empty or being drained this cycle.
  assign can_take   = (state == XFER) && !in_done && (!o_send_valid || i_send_ready);
  assign take       = can_take && cur_valid;
  assign out_hs     = o_send_valid && i_send_ready;
  assign o_s0_ready = can_take && (o_grant == 2'd0);
  assign o_s1_ready = can_take && (o_grant == 2'd1);
  assign o_s2_ready = can_take && (o_grant == 2'd2);
  assign o_busy     = (state != IDLE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= IDLE;
      rr_ptr       <= 2'd2;
      o_grant      <= 2'd3;
      o_send_len   <= '0;
      o_send_data  <= 8'd0;
      o_send_valid <= 1'b0;
      o_send_last  <= 1'b0;
      beat_cnt     <= '0;
      gap_cnt      <= '0;
      in_done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state      <= XFER;
            o_grant    <= pick;
            rr_ptr     <= pick;
            o_send_len <= pick_user;
            beat_cnt   <= '0;
            in_done    <= 1'b0;
          end
        end
        XFER: begin
          if (take) begin
            o_send_data  <= cur_data;
            o_send_last  <= cur_last;
            o_send_valid <= 1'b1;
            if (beat_cnt != '1) beat_cnt <= beat_cnt + 1'b1;
            if (cur_last) in_done <= 1'b1;
          end else if (out_hs) begin
            o_send_valid <= 1'b0;
            o_send_last  <= 1'b0;
          end
          // Once the last input beat is in, no take can coincide with this handshake.
          if (out_hs && o_send_last) begin
            gap_cnt <= '0;
            if (GAP_CYCLES == 0) begin
              state   <= IDLE;
              o_grant <= 2'd3;
            end else begin
              state <= GAP;
            end
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state   <= IDLE;
            o_grant <= 2'd3;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UDP_TX_ARB_LEN_CHECK_EN
  logic             len_bad;
  logic [LEN_W:0]   beats_seen;

  // beat_cnt excludes the beat being accepted now, hence the +1.
  assign beats_seen = {1'b0, beat_cnt} + (LEN_W + 1)'(1);
  assign len_bad    = (beats_seen != {1'b0, o_send_len}) || (o_send_len == '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_err_len <= 1'b0;
      o_err_cnt <= 8'd0;
    end else begin
      o_err_len <= 1'b0;
      if (take && cur_last && len_bad) begin
        o_err_len <= 1'b1;
        if (o_err_cnt != 8'hFF) o_err_cnt <= o_err_cnt + 1'b1;
      end
    end
  end
`else
  assign o_err_len = 1'b0;
  assign o_err_cnt = 8'd0;
`endif

endmodule
